// File: rtl/i2c_reg_reader.sv
// i2c_reg_reader: drives a byte-level I2C master through a register read
// (START+ADR/W, register byte, RESTART+ADR/R, N data bytes) and stores the
// bytes in a small buffer readable combinationally through rd_idx.
// Optional watchdog: define I2C_TIMEOUT_EN to abort stalled transactions
// after TIMEOUT_CYC cycles in one state and raise the sticky err flag.
module i2c_reg_reader #(
  parameter logic [6:0]  DEV_ADR     = 7'h77,
  parameter int          MAX_BYTES   = 22,
  parameter int          PTR_W       = 5,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_reg,
  input  logic [PTR_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             isReady,
  output logic             start,
  output logic             send,
  output logic [7:0]       datasend,
  input  logic             sended,
  output logic             receive,
  input  logic [7:0]       datareceive,
  input  logic             received,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [7:0]       out,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, TX_ADRW, TX_REG, TX_ADRR, RX, FIN} state_t;

  state_t           state, state_next;
  logic             sended_q, received_q;
  logic             sended_rise, received_rise;
  logic             entry;      // first cycle in the current state
  logic             rx_more;    // a byte was just stored and more are expected
  logic [7:0]       reg_q;
  logic [PTR_W-1:0] len_q, len_clamp, idx;
  logic [7:0]       buffer [MAX_BYTES];
  logic             accept, store, timeout;

  // Master handshakes are level flags; only their rising edges count.
  assign sended_rise   = sended & ~sended_q;
  assign received_rise = received & ~received_q;

  // Requests longer than the buffer are truncated so writes stay in range.
  assign len_clamp = (32'(cmd_len) >= MAX_BYTES) ? PTR_W'(MAX_BYTES - 1) : cmd_len;

  assign out = (32'(rd_idx) < MAX_BYTES) ? buffer[rd_idx] : 8'h00;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    start      = 1'b0;
    send       = 1'b0;
    receive    = 1'b0;
    datasend   = 8'h00;
    done       = 1'b0;
    accept     = 1'b0;
    store      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = WAIT_RDY;
        end
      end
      WAIT_RDY: if (isReady) state_next = TX_ADRW;
      TX_ADRW: begin
        datasend = {DEV_ADR, 1'b0};
        start    = 1'b1;
        send     = entry;
        if (sended_rise) state_next = TX_REG;
      end
      TX_REG: begin
        datasend = reg_q;
        send     = entry;
        if (sended_rise) state_next = TX_ADRR;
      end
      TX_ADRR: begin
        datasend = {DEV_ADR, 1'b1};
        start    = 1'b1;
        send     = entry;
        if (sended_rise) state_next = RX;
      end
      RX: begin
        receive = entry | rx_more;
        if (received_rise) begin
          store = 1'b1;
          if (idx == len_q) state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  // Edge-detect history, entry flag, receive re-arm and write index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sended_q   <= 1'b0;
      received_q <= 1'b0;
      entry      <= 1'b0;
      rx_more    <= 1'b0;
      idx        <= '0;
    end else begin
      sended_q   <= sended;
      received_q <= received;
      entry      <= (state_next != state);
      rx_more    <= store && (state_next == RX);
      if (accept)     idx <= '0;
      else if (store) idx <= idx + PTR_W'(1);
    end
  end

  // Command latch; only meaningful once a request is accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      reg_q <= cmd_reg;
      len_q <= len_clamp;
    end
  end

  // Receive buffer: cleared by reset, otherwise keeps contents across transactions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_BYTES; i++) buffer[i] <= 8'h00;
    end else if (store) begin
      buffer[idx] <= datareceive;
    end
  end

`ifdef I2C_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        err_q;
  logic        timed;

  assign timed   = state inside {WAIT_RDY, TX_ADRW, TX_REG, TX_ADRR, RX};
  assign timeout = timed && (tcnt == TIMEOUT_CYC - 16'd1);
  assign err     = err_q;

  // Per-state watchdog: restarts on every state change, err cleared by a new request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!timed || (state_next != state)) tcnt <= '0;
      else                                 tcnt <= tcnt + 16'd1;
      if (accept)       err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_reader.sv
// Directed bench for i2c_reg_reader: plays the I2C master by hand and checks
// bytes, strobes, buffer contents, clamping, ignored events and reset.
module tb_i2c_reg_reader;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_reg = 8'h00;
  logic [PW-1:0] cmd_len = '0;
  logic          isReady = 1'b1;
  logic          sended = 1'b0;
  logic [7:0]    datareceive = 8'h00;
  logic          received = 1'b0;
  logic [PW-1:0] rd_idx = '0;
  logic          cmd_ready, start, send, receive, done, err;
  logic [7:0]    datasend, out;

  int checks = 0;
  int errors = 0;
  int rcv_cnt = 0;
  int done_cnt = 0;

  i2c_reg_reader #(.DEV_ADR(7'h77), .MAX_BYTES(22), .PTR_W(PW), .TIMEOUT_CYC(16'd100)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .isReady(isReady), .start(start), .send(send), .datasend(datasend),
    .sended(sended), .receive(receive), .datareceive(datareceive), .received(received),
    .rd_idx(rd_idx), .out(out), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Count receive and done strobes
  always @(negedge clk) begin
    if (receive) rcv_cnt <= rcv_cnt + 1;
    if (done)    done_cnt <= done_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [7:0] pat(input int i, input logic [7:0] key);
    return 8'(i * 37) ^ key;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] r, input logic [PW-1:0] l);
    cmd_reg   = r;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (send) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_recv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (receive) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic tx_step(input logic [7:0] d, input logic s, input string tag);
    bit ok;
    wait_send(ok);
    chk({tag, "_send"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, 32'(datasend), 32'(d));
    chk({tag, "_start"}, 32'(start), 32'(s));
  endtask

  task automatic ack();
    @(negedge clk);
    sended = 1'b1;
    @(negedge clk);
    sended = 1'b0;
  endtask

  task automatic give_byte(input logic [7:0] b);
    @(negedge clk);
    datareceive = b;
    received    = 1'b1;
    @(negedge clk);
    received    = 1'b0;
  endtask

  task automatic header(input logic [7:0] r, input string tag);
    tx_step(8'hEE, 1'b1, {tag, "_adrw"}); ack();
    tx_step(r,     1'b0, {tag, "_reg"});  ack();
    tx_step(8'hEF, 1'b1, {tag, "_adrr"}); ack();
  endtask

  initial begin
    bit ok;
    int n, got, rb, db;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_send", 32'(send), 32'd0);
    chk("rst_receive", 32'(receive), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_datasend", 32'(datasend), 32'h00);
    chk("rst_out", 32'(out), 32'h00);
    reset = 1'b1;
    @(negedge clk);

    // Single-byte read of register D0
    #1 rb = rcv_cnt; db = done_cnt;
    issue(8'hD0, 5'd0);
    chk("t1_busy", 32'(cmd_ready), 32'd0);
    header(8'hD0, "t1");
    wait_recv(ok);
    chk("t1_recv", 32'(ok), 32'd1);
    give_byte(8'h55);
    chk("t1_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(cmd_ready), 32'd1);
    rd_idx = 5'd0;
    #1;
    chk("t1_out0", 32'(out), 32'h55);
    chk("t1_nrecv", 32'(rcv_cnt - rb), 32'd1);
    chk("t1_ndone", 32'(done_cnt - db), 32'd1);
    @(negedge clk);

    // Full 22-byte read of register AA
    #1 rb = rcv_cnt; db = done_cnt;
    issue(8'hAA, 5'd21);
    header(8'hAA, "t2");
    for (int i = 0; i < 22; i++) begin
      wait_recv(ok);
      chk("t2_recv", 32'(ok), 32'd1);
      give_byte(pat(i, 8'h3C));
    end
    chk("t2_done", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk("t2_nrecv", 32'(rcv_cnt - rb), 32'd22);
    chk("t2_ndone", 32'(done_cnt - db), 32'd1);
    for (int i = 0; i < 22; i++) begin
      rd_idx = PW'(i);
      #1;
      chk("t2_out", 32'(out), 32'(pat(i, 8'h3C)));
    end
    rd_idx = 5'd22;
    #1;
    chk("t2_out22", 32'(out), 32'h00);
    rd_idx = 5'd31;
    #1;
    chk("t2_out31", 32'(out), 32'h00);
    @(negedge clk);

    // Over-long request is clamped to the buffer depth
    #1 db = done_cnt;
    issue(8'h5A, 5'd31);
    header(8'h5A, "t3");
    n = 0;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      wait_recv(ok);
      if (!ok) break;
      give_byte(pat(i, 8'hA5));
      n++;
      if (done) got = n;
    end
    #1;
    chk("t3_nbytes", 32'(n), 32'd22);
    chk("t3_done_at", 32'(got), 32'd22);
    chk("t3_ndone", 32'(done_cnt - db), 32'd1);
    rd_idx = 5'd0;
    #1;
    chk("t3_out0", 32'(out), 32'(pat(0, 8'hA5)));
    rd_idx = 5'd21;
    #1;
    chk("t3_out21", 32'(out), 32'(pat(21, 8'hA5)));
    @(negedge clk);

    // Spurious received edge in TX_REG, cmd_valid during RX
    #1 rb = rcv_cnt; db = done_cnt;
    issue(8'h33, 5'd2);
    tx_step(8'hEE, 1'b1, "t4_adrw"); ack();
    tx_step(8'h33, 1'b0, "t4_reg");
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    @(negedge clk);
    chk("t4_still_reg", 32'(datasend), 32'h33);
    chk("t4_no_recv", 32'(receive), 32'd0);
    ack();
    tx_step(8'hEF, 1'b1, "t4_adrr"); ack();
    wait_recv(ok);
    chk("t4_recv", 32'(ok), 32'd1);
    cmd_reg   = 8'h99;
    cmd_valid = 1'b1;
    give_byte(8'hC1);
    cmd_valid = 1'b0;
    chk("t4_busy", 32'(cmd_ready), 32'd0);
    for (int i = 1; i < 3; i++) begin
      wait_recv(ok);
      chk("t4_recv", 32'(ok), 32'd1);
      give_byte(8'hC1 + 8'(i));
    end
    chk("t4_done", 32'(done), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("t4_no_queue", 32'(cmd_ready), 32'd1);
    chk("t4_nrecv", 32'(rcv_cnt - rb), 32'd3);
    chk("t4_ndone", 32'(done_cnt - db), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd_idx = PW'(i);
      #1;
      chk("t4_out", 32'(out), 32'(8'hC1 + 8'(i)));
    end
    rd_idx = 5'd3;
    #1;
    chk("t4_hold3", 32'(out), 32'(pat(3, 8'hA5)));
    @(negedge clk);

    // Reset in the middle of RX
    issue(8'h44, 5'd5);
    header(8'h44, "t5");
    for (int i = 0; i < 2; i++) begin
      wait_recv(ok);
      give_byte(8'h70 + 8'(i));
    end
    wait_recv(ok);
    chk("t5_recv", 32'(ok), 32'd1);
    #1 db = done_cnt;
    reset = 1'b0;
    #1;
    chk("t5_receive", 32'(receive), 32'd0);
    chk("t5_send", 32'(send), 32'd0);
    chk("t5_start", 32'(start), 32'd0);
    chk("t5_datasend", 32'(datasend), 32'h00);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_out3", 32'(out), 32'h00);
    rd_idx = 5'd0;
    #1;
    chk("t5_out0", 32'(out), 32'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_ndone", 32'(done_cnt - db), 32'd0);
    chk("t5_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);

`ifdef I2C_TIMEOUT_EN
    // Master never accepts the register byte
    #1 db = done_cnt;
    issue(8'h12, 5'd0);
    tx_step(8'hEE, 1'b1, "t6_adrw"); ack();
    tx_step(8'h12, 1'b0, "t6_reg");
    repeat (80) @(negedge clk);
    chk("t6_wait_busy", 32'(cmd_ready), 32'd0);
    chk("t6_wait_err", 32'(err), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    chk("t6_err", 32'(err), 32'd1);
    chk("t6_idle", 32'(cmd_ready), 32'd1);
    chk("t6_ndone", 32'(done_cnt - db), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_reg_reader.md
I2C_REG_READER -- requirements
Module: i2c_reg_reader

Interface
REQ-001 SHALL provide parameter DEV_ADR, default 7'h77, 7-bit I2C device address.
REQ-002 SHALL provide parameter MAX_BYTES, default 22, receive buffer depth (2..256).
REQ-003 SHALL provide parameter PTR_W, default 5, buffer index width; 2^PTR_W >= MAX_BYTES.
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 16'hFFFF, watchdog limit in clk cycles.
REQ-005 Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request a register read; sampled only in IDLE.
- cmd_reg  in  8  first register address to read.
- cmd_len  in  PTR_W  byte count minus one (0 = one byte).
- cmd_ready  out  1  high only in IDLE.
- isReady  in  1  I2C master idle.
- start  out  1  generate START/RESTART with the current datasend byte.
- send  out  1  one-cycle strobe: next datasend byte valid.
- datasend  out  8  address/register byte to master.
- sended  in  1  master byte-accepted flag; rising edge = accepted.
- receive  out  1  one-cycle strobe: master may clock in next byte.
- datareceive  in  8  byte from master.
- received  in  1  master byte-ready flag; rising edge = byte valid.
- rd_idx  in  PTR_W  buffer read index.
- out  out  8  buffer[rd_idx]; 8'h00 if rd_idx >= MAX_BYTES.
- done  out  1  one-cycle pulse, transaction complete.
- err  out  1  sticky: last transaction aborted.

Function
REQ-006 SHALL detect sended/received edges with a registered previous value, in clk domain only (no data-as-clock).
REQ-007 States: IDLE, WAIT_RDY, TX_ADRW, TX_REG, TX_ADRR, RX, FIN.
REQ-008 IDLE: cmd_valid=1 -> latch cmd_reg, min(cmd_len, MAX_BYTES-1), clear idx and err -> WAIT_RDY.
REQ-009 WAIT_RDY: isReady=1 -> TX_ADRW next cycle.
REQ-010 TX_ADRW: datasend={DEV_ADR,0}, start=1, send pulsed on entry; sended rise -> TX_REG.
REQ-011 TX_REG: datasend=cmd_reg, start=0, send pulsed on entry; sended rise -> TX_ADRR.
REQ-012 TX_ADRR: datasend={DEV_ADR,1}, start=1 (RESTART), send pulsed on entry; sended rise -> RX.
REQ-013 RX: receive pulsed on entry and one cycle after each stored byte; received rise -> buffer[idx]<=datareceive, idx+1.
REQ-014 RX with idx==latched length on received rise: store, no further receive pulse -> FIN.
REQ-015 FIN: done=1 for one cycle -> IDLE.
REQ-016 datasend=8'h00 and start=0 outside TX states.
REQ-017 Edge on sended or received in a state not expecting it SHALL be ignored.
REQ-018 cmd_valid outside IDLE SHALL be ignored (no queueing).
REQ-019 cmd_len >= MAX_BYTES SHALL be clamped to MAX_BYTES-1; writes never exceed buffer.
REQ-020 Buffer SHALL hold contents between transactions; new transaction overwrites from index 0.
REQ-021 out is combinational from rd_idx, zero latency.

Reset
REQ-022 reset=0 SHALL immediately force state IDLE; start, send, receive, done, err = 0; datasend = 8'h00; cmd_ready = 1.
REQ-023 reset SHALL clear all buffer entries to 8'h00 and edge-detect registers to 0.
REQ-024 Reset mid-transaction SHALL abandon it without done pulse.

Configuration
REQ-025 Macro I2C_TIMEOUT_EN defined: per-state cycle counter in WAIT_RDY, TX_*, RX; reaching TIMEOUT_CYC -> err=1, IDLE, no done.
REQ-026 I2C_TIMEOUT_EN undefined: no counter, FSM waits indefinitely, err tied 0.

Verification
REQ-027 cmd_reg=8'hD0, cmd_len=0, master acks -> datasend 8'hEE(start=1), 8'hD0, 8'hEF(start=1); byte 8'h55 -> buffer[0]=8'h55, one done.
REQ-028 cmd_reg=8'hAA, cmd_len=21 -> 22 receive pulses, buffer[0..21] = stimulus bytes, out follows rd_idx, rd_idx=22 -> out 8'h00.
REQ-029 cmd_len=31 with MAX_BYTES=22 -> exactly 22 bytes stored, done asserted after 22nd.
REQ-030 Spurious received rise during TX_REG and cmd_valid during RX -> ignored, transaction unchanged.
REQ-031 reset low mid-RX -> all outputs reset values same cycle, buffer zeroed, no done.
REQ-032 I2C_TIMEOUT_EN, TIMEOUT_CYC=100, sended held low in TX_REG -> err=1 after 100 cycles, IDLE, cmd_ready=1.
